// File: rtl/ysyx_24080014_fetch.sv
// Multi-cycle instruction fetch: owns the PC, issues one memory request at a time,
// buffers the returned word for the decoder and squashes stale responses on redirect.
module ysyx_24080014_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic            drop_q;
  logic [XLEN-1:0] redir_pc;

  assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign req_addr = pc_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_REQ;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:  if (req_ready) state_d = S_WAIT;
      // any response ends the wait; only a clean, unredirected one is kept
      S_WAIT: if (rsp_valid) state_d = (drop_q || redirect_valid) ? S_REQ : S_HOLD;
      S_HOLD: if (redirect_valid || inst_ready) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    req_valid  = (state_q == S_REQ)  && rst;
    inst_valid = (state_q == S_HOLD) && rst;
    busy       = (state_q != S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      case (state_q)
        S_REQ: begin
          // a redirect racing an accepted request makes that request stale
          if (redirect_valid) begin
            pc_q <= redir_pc;
            if (req_ready) drop_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (rsp_valid) begin
            drop_q <= 1'b0;
            if (redirect_valid) pc_q <= redir_pc;
            else if (!drop_q) begin
              inst    <= rsp_data;
              inst_pc <= pc_q;
            end
          end else if (redirect_valid) begin
            pc_q   <= redir_pc;
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid)  pc_q <= redir_pc;
          else if (inst_ready) pc_q <= pc_q + XLEN'(4);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_fetch.sv
// Scoreboarded bench for the fetch stage: expected {inst, pc} pairs are queued when
// a response is driven and compared when the decoder side presents an instruction.
module tb_ysyx_24080014_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        busy;

  typedef struct { logic [31:0] data; logic [31:0] pc; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  logic [31:0] tb_pc;

  ysyx_24080014_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  // One full fetch from REQ; optional decoder stall and optional redirect at consume.
  task automatic fetch(input logic [31:0] data, input int lat, input int stall,
                       input bit redir, input logic [31:0] rpc);
    exp_t e;
    int   n;
    e = '{data: 32'h0, pc: 32'h0};
    total++; if (req_valid !== 1'b1 || req_addr !== tb_pc) begin bad++;
      $display("FAIL fetch_req got v=%0b addr=%h want v=1 addr=%h", req_valid, req_addr, tb_pc); end
    req_ready = 1'b1; step(); req_ready = 1'b0;
    total++; if (req_valid !== 1'b0 || busy !== 1'b1) begin bad++;
      $display("FAIL fetch_wait got req_valid=%0b busy=%0b want 0/1", req_valid, busy); end
    repeat (lat) step();
    rsp_valid = 1'b1; rsp_data = data;
    sb.push_back('{data: data, pc: tb_pc});
    step(); rsp_valid = 1'b0;
    n = 0;
    while (inst_valid !== 1'b1 && n < 8) begin step(); n++; end
    total++; if (inst_valid !== 1'b1) begin bad++;
      $display("FAIL fetch_inst_valid timeout got=%0b want=1", inst_valid); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (inst !== e.data || inst_pc !== e.pc) begin bad++;
        $display("FAIL fetch_inst got %h@%h want %h@%h", inst, inst_pc, e.data, e.pc); end
    end
    repeat (stall) begin
      step();
      total++; if (inst_valid !== 1'b1 || req_valid !== 1'b0 || inst !== e.data || inst_pc !== e.pc) begin bad++;
        $display("FAIL stall_hold got v=%0b rv=%0b %h@%h want 1/0 %h@%h",
                 inst_valid, req_valid, inst, inst_pc, e.data, e.pc); end
    end
    inst_ready = 1'b1;
    if (redir) begin redirect_valid = 1'b1; redirect_pc = rpc; tb_pc = {rpc[31:2], 2'b00}; end
    else tb_pc = tb_pc + 32'd4;
    step();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    total++; if (req_valid !== 1'b1 || req_addr !== tb_pc || inst_valid !== 1'b0) begin bad++;
      $display("FAIL fetch_next got v=%0b addr=%h iv=%0b want v=1 addr=%h iv=0",
               req_valid, req_addr, inst_valid, tb_pc); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin
      step();
      total++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin bad++;
        $display("FAIL reset_hold got rv=%0b iv=%0b want 0/0", req_valid, inst_valid); end
    end
    rst = 1'b1; #1;
    total++; if (req_valid !== 1'b1 || req_addr !== RST_PC || inst_valid !== 1'b0) begin bad++;
      $display("FAIL reset_release got rv=%0b addr=%h iv=%0b want 1/%h/0",
               req_valid, req_addr, inst_valid, RST_PC); end
    tb_pc = RST_PC;
  endtask

  task automatic test_seq_fetch();
    fetch(32'h0050_0093, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_decoder_stall();
    fetch(32'h0010_0113, 2, 5, 1'b0, 32'h0);
  endtask

  task automatic test_redirect_wait();
    req_ready = 1'b1; step(); req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; step(); redirect_valid = 1'b0;
    step();
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF; step(); rsp_valid = 1'b0;
    tb_pc = 32'h8000_0100;
    total++; if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== tb_pc) begin bad++;
      $display("FAIL redirect_wait got iv=%0b rv=%0b addr=%h want 0/1/%h",
               inst_valid, req_valid, req_addr, tb_pc); end
  endtask

  task automatic test_redirect_with_rsp();
    req_ready = 1'b1; step(); req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0203;
    rsp_valid = 1'b1; rsp_data = 32'h1111_1111;
    step();
    redirect_valid = 1'b0; rsp_valid = 1'b0;
    tb_pc = 32'h8000_0200;
    total++; if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== tb_pc) begin bad++;
      $display("FAIL redirect_rsp got iv=%0b rv=%0b addr=%h want 0/1/%h",
               inst_valid, req_valid, req_addr, tb_pc); end
    fetch(32'h0020_0193, 1, 0, 1'b0, 32'h0);
  endtask

  task automatic test_redirect_req();
    // redirect racing an accepted request: request is stale, its response dropped
    req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    step();
    req_ready = 1'b0; redirect_valid = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h2222_2222; step(); rsp_valid = 1'b0;
    tb_pc = 32'h8000_0300;
    total++; if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== tb_pc) begin bad++;
      $display("FAIL redirect_req_ready got iv=%0b rv=%0b addr=%h want 0/1/%h",
               inst_valid, req_valid, req_addr, tb_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0402; step(); redirect_valid = 1'b0;
    tb_pc = 32'h8000_0400;
    total++; if (req_valid !== 1'b1 || req_addr !== tb_pc) begin bad++;
      $display("FAIL redirect_req_idle got rv=%0b addr=%h want 1/%h", req_valid, req_addr, tb_pc); end
  endtask

  task automatic test_redirect_hold();
    fetch(32'h0030_0213, 0, 2, 1'b1, 32'h8000_0500);
    fetch(32'h0040_0293, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; step(); redirect_valid = 1'b0;
    tb_pc = 32'hFFFF_FFFC;
    fetch(32'h0000_0013, 1, 0, 1'b0, 32'h0);
    total++; if (req_addr !== 32'h0) begin bad++;
      $display("FAIL wrap got addr=%h want 00000000", req_addr); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      fetch($urandom, (i % 3 == 0) ? 1 : 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_wait();
    req_ready = 1'b1; step(); req_ready = 1'b0;
    rst = 1'b0; step(); rst = 1'b1;
    rsp_valid = 1'b1; rsp_data = 32'h3333_3333; step(); rsp_valid = 1'b0;
    tb_pc = RST_PC;
    total++; if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== RST_PC) begin bad++;
      $display("FAIL reset_wait got iv=%0b rv=%0b addr=%h want 0/1/%h",
               inst_valid, req_valid, req_addr, RST_PC); end
    step();
    total++; if (inst_valid !== 1'b0 || req_valid !== 1'b1) begin bad++;
      $display("FAIL reset_wait_late got iv=%0b rv=%0b want 0/1", inst_valid, req_valid); end
    fetch(32'h0050_0313, 0, 0, 1'b0, 32'h0);
  endtask

  initial begin
    step();
    test_reset();
    test_seq_fetch();
    test_decoder_stall();
    test_redirect_wait();
    test_redirect_with_rsp();
    test_redirect_req();
    test_redirect_hold();
    test_wrap();
    test_back_to_back();
    test_reset_wait();
    total++; if (sb.size() != 0) begin bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
